// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a circular output FIFO.
// Decodes in_inst on push; the buffer head drives out_* one cycle later.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [15:0]     illegal_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = 1;
  localparam logic [AW-1:0] PTR_ONE   = 1;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_SH  = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] sx;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;

  logic [XLEN-1:0] mem_imm_q [DEPTH];
  logic [XLEN-1:0] mem_imm_d [DEPTH];
  logic [2:0]      mem_fmt_q [DEPTH];
  logic [2:0]      mem_fmt_d [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   illegal_cnt_q, illegal_cnt_d;

  logic full;
  logic push;
  logic pop;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign sx     = {XLEN{in_inst[31]}};

  // Each format starts from the all-sign vector and overwrites its low field.
  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_ILL;
    case (opcode)
      OP_LOAD, OP_JALR: begin
        dec_fmt       = FMT_I;
        dec_imm       = sx;
        dec_imm[11:0] = in_inst[31:20];
      end
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_fmt      = FMT_SH;
          dec_imm[4:0] = in_inst[24:20];
          if (XLEN == 64) dec_imm[5] = in_inst[25];
        end else begin
          dec_fmt       = FMT_I;
          dec_imm       = sx;
          dec_imm[11:0] = in_inst[31:20];
        end
      end
      OP_STORE: begin
        dec_fmt       = FMT_S;
        dec_imm       = sx;
        dec_imm[11:0] = {in_inst[31:25], in_inst[11:7]};
      end
      OP_BR: begin
        dec_fmt       = FMT_B;
        dec_imm       = sx;
        dec_imm[12:0] = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec_fmt       = FMT_U;
        dec_imm       = sx;
        dec_imm[31:0] = {in_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        dec_fmt       = FMT_J;
        dec_imm       = sx;
        dec_imm[20:0] = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      OP_REG: begin
        dec_fmt = FMT_R;
      end
      default: begin
        dec_fmt = FMT_ILL;
      end
    endcase
  end

  assign full      = (count_q == DEPTH_CNT);
  assign in_ready  = rst_n & ~full;
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    mem_imm_d = mem_imm_q;
    mem_fmt_d = mem_fmt_q;
    if (push) begin
      mem_imm_d[wr_ptr_q] = dec_imm;
      mem_fmt_d[wr_ptr_q] = dec_fmt;
    end
  end

  always_comb begin
    wr_ptr_d      = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d      = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d       = count_q;
    illegal_cnt_d = illegal_cnt_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (push && dec_fmt == FMT_ILL && illegal_cnt_q != 16'hFFFF)
      illegal_cnt_d = illegal_cnt_q + 16'd1;
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_imm_q <= mem_imm_d;
    mem_fmt_q <= mem_fmt_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      illegal_cnt_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign out_imm     = out_valid ? mem_imm_q[rd_ptr_q] : '0;
  assign out_fmt     = out_valid ? mem_fmt_q[rd_ptr_q] : 3'd0;
  assign out_illegal = out_valid && (mem_fmt_q[rd_ptr_q] == FMT_ILL);
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit/DEPTH=2 and a 64-bit/DEPTH=4 instance
// checked every cycle against a queue-based reference model.
module tb_imm_gen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_illegal;
  logic [31:0] in_inst = '0, out_imm;
  logic [2:0]  out_fmt;
  logic [15:0] illegal_cnt;

  logic        in_valid_w = 1'b0, in_ready_w, out_valid_w, out_ready_w = 1'b1, out_illegal_w;
  logic [31:0] in_inst_w = '0;
  logic [63:0] out_imm_w;
  logic [2:0]  out_fmt_w;
  logic [15:0] illegal_cnt_w;

  int n_chk = 0;
  int n_pass = 0;

  ent_t        q32[$];
  ent_t        q64[$];
  logic [15:0] cnt32 = '0, cnt64 = '0;
  bit          pushed32 = 1'b0;

  imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(4)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_w), .in_ready(in_ready_w), .in_inst(in_inst_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w),
    .out_imm(out_imm_w), .out_fmt(out_fmt_w), .out_illegal(out_illegal_w),
    .illegal_cnt(illegal_cnt_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Reference decode written from the instruction-set view: signed field values scaled.
  function automatic ent_t ref_dec(input logic [31:0] i, input bit x64);
    ent_t   e;
    longint v;
    v     = 0;
    e.fmt = 3'd7;
    case (i[6:0])
      7'h03, 7'h67: begin v = longint'($signed(i[31:20])); e.fmt = 3'd1; end
      7'h13: begin
        if (i[14:12] == 3'd1 || i[14:12] == 3'd5) begin
          v = x64 ? longint'(i[25:20]) : longint'(i[24:20]);
          e.fmt = 3'd6;
        end else begin
          v = longint'($signed(i[31:20]));
          e.fmt = 3'd1;
        end
      end
      7'h23: begin v = longint'($signed({i[31:25], i[11:7]})); e.fmt = 3'd2; end
      7'h63: begin v = 2 * longint'($signed({i[31], i[7], i[30:25], i[11:8]})); e.fmt = 3'd3; end
      7'h37, 7'h17: begin v = 4096 * longint'($signed(i[31:12])); e.fmt = 3'd4; end
      7'h6F: begin v = 2 * longint'($signed({i[31], i[19:12], i[20], i[30:21]})); e.fmt = 3'd5; end
      7'h33: begin v = 0; e.fmt = 3'd0; end
      default: begin v = 0; e.fmt = 3'd7; end
    endcase
    e.imm = x64 ? 64'(v) : {32'h0, v[31:0]};
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0]  ops[10];
    int          k;
    ops = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h13};
    r = $urandom();
    k = $urandom_range(0, 10);
    if (k < 10) r[6:0] = ops[k];
    return r;
  endfunction

  // Sample at the falling edge, then advance the model across the next rising edge.
  task automatic cycle();
    bit   rdy32, rdy64, push, pop;
    ent_t e;
    @(negedge clk);
    rdy32 = rst_n && (q32.size() < 2);
    rdy64 = rst_n && (q64.size() < 4);
    chk("in_ready32", in_ready, rdy32);
    chk("out_valid32", out_valid, q32.size() != 0);
    chk("out_imm32", out_imm, (q32.size() != 0) ? q32[0].imm : 64'd0);
    chk("out_fmt32", out_fmt, (q32.size() != 0) ? q32[0].fmt : 3'd0);
    chk("out_illegal32", out_illegal, (q32.size() != 0) && q32[0].fmt == 3'd7);
    chk("illegal_cnt32", illegal_cnt, cnt32);
    chk("in_ready64", in_ready_w, rdy64);
    chk("out_valid64", out_valid_w, q64.size() != 0);
    chk("out_imm64", out_imm_w, (q64.size() != 0) ? q64[0].imm : 64'd0);
    chk("out_fmt64", out_fmt_w, (q64.size() != 0) ? q64[0].fmt : 3'd0);
    chk("out_illegal64", out_illegal_w, (q64.size() != 0) && q64[0].fmt == 3'd7);
    chk("illegal_cnt64", illegal_cnt_w, cnt64);
    if (!rst_n) begin
      q32.delete(); q64.delete();
      cnt32 = '0; cnt64 = '0;
      pushed32 = 1'b0;
    end else begin
      pop  = (q32.size() != 0) && out_ready;
      push = in_valid && rdy32;
      if (pop) void'(q32.pop_front());
      if (push) begin
        e = ref_dec(in_inst, 1'b0);
        q32.push_back(e);
        if (e.fmt == 3'd7 && cnt32 != 16'hFFFF) cnt32++;
      end
      pushed32 = push;
      pop  = (q64.size() != 0) && out_ready_w;
      push = in_valid_w && rdy64;
      if (pop) void'(q64.pop_front());
      if (push) begin
        e = ref_dec(in_inst_w, 1'b1);
        q64.push_back(e);
        if (e.fmt == 3'd7 && cnt64 != 16'hFFFF) cnt64++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push32(input logic [31:0] inst, input logic [31:0] imm, input logic [2:0] fmt);
    in_valid = 1'b1; in_inst = inst; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("dir_imm32", out_imm, imm);
    chk("dir_fmt32", out_fmt, fmt);
    cycle();
  endtask

  task automatic push64(input logic [31:0] inst, input logic [63:0] imm, input logic [2:0] fmt);
    in_valid_w = 1'b1; in_inst_w = inst; out_ready_w = 1'b1;
    cycle();
    in_valid_w = 1'b0;
    chk("dir_imm64", out_imm_w, imm);
    chk("dir_fmt64", out_fmt_w, fmt);
    cycle();
  endtask

  initial begin
    int n;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    push32(32'hFFF00093, 32'hFFFFFFFF, 3'd1);
    push32(32'hFE000EE3, 32'hFFFFFFFC, 3'd3);
    push32(32'h123450B7, 32'h12345000, 3'd4);
    push32(32'h01F09093, 32'h0000001F, 3'd6);
    push32(32'h0000007F, 32'h00000000, 3'd7);
    chk("illegal_one", illegal_cnt, 16'd1);
    push64(32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1);
    push64(32'h03F09093, 64'h000000000000003F, 3'd6);

    // Backpressure: third offer must wait for two pops.
    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = 32'hFFF00093; cycle();
    in_inst = 32'hFE000EE3; cycle();
    in_inst = 32'h123450B7; cycle();
    chk("bp_full_ready", in_ready, 1'b0);
    chk("bp_head", out_imm, 32'hFFFFFFFF);
    out_ready = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!pushed32 && n < 8);
    chk("bp_accept_cycles", n, 2);
    in_valid = 1'b0;
    repeat (3) cycle();

    // Streaming: one push per cycle with a single-entry steady state.
    in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      in_inst = rand_inst();
      cycle();
      if (pushed32) n++;
    end
    chk("stream_pushes", n, 20);
    in_valid = 1'b0;
    cycle();

    for (int i = 0; i < 400; i++) begin
      in_valid    = $urandom_range(0, 1);
      out_ready   = ($urandom_range(0, 9) < 6);
      in_inst     = rand_inst();
      in_valid_w  = $urandom_range(0, 1);
      out_ready_w = ($urandom_range(0, 9) < 4);
      in_inst_w   = rand_inst();
      cycle();
    end
    in_valid_w = 1'b0; out_ready_w = 1'b1;

    // Reset with two buffered illegal entries.
    in_valid = 1'b1; out_ready = 1'b0; in_inst = 32'h0000007F;
    repeat (3) cycle();
    in_valid = 1'b0;
    rst_n = 1'b0;
    cycle();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_illegal_cnt", illegal_cnt, 16'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", in_ready, 1'b1);
    cycle();

    in_valid = 1'b1; out_ready = 1'b1; in_inst = 32'h0000007F;
    repeat (65540) cycle();
    chk("illegal_sat", illegal_cnt, 16'hFFFF);
    in_valid = 1'b0;
    repeat (2) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
